// File: rtl/vga_pkg.sv
// Timing constants and helpers shared by the VGA scanout path.
// Default geometry is 640x480@60 on a 25 MHz pixel grid derived from CLOCK_50.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int COORD_W = 11;
    localparam int DATA_W  = 8;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };

    // Bar index drops x[9] so the 128-px bars repeat from x=512 onward.
    function automatic logic [DATA_W-1:0] grey_bar(input logic [COORD_W-1:0] x);
        return {1'b0, x[8:7], 5'b00000};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider and h/v raster counters with sync/active decode.
// Exposes next-count values so the read address can be registered in step with the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] h_nxt,
    output logic [COORD_W-1:0] v_nxt,
    output logic               active_nxt,
    output logic               hs,
    output logic               vs,
    output logic               active,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(TIMING.h_active);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(TIMING.h_active + TIMING.h_fp);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(TIMING.h_active + TIMING.h_fp + TIMING.h_sync - 1);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(TIMING.h_active + TIMING.h_fp + TIMING.h_sync + TIMING.h_bp - 1);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(TIMING.v_active);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(TIMING.v_active + TIMING.v_fp);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(TIMING.v_active + TIMING.v_fp + TIMING.v_sync - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(TIMING.v_active + TIMING.v_fp + TIMING.v_sync + TIMING.v_bp - 1);

    logic               pix_en_r;
    logic [COORD_W-1:0] h_cnt_r;
    logic [COORD_W-1:0] v_cnt_r;
    logic               hs_r;
    logic               vs_r;
    logic               active_r;
    logic               frame_start_r;
    logic               restart_r;
    logic [COORD_W-1:0] h_nxt_s;
    logic [COORD_W-1:0] v_nxt_s;
    logic               act_nxt_s;
    logic               hs_nxt_s;
    logic               vs_nxt_s;

    // Next raster position and its decoded sync/active flags.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_nxt_s = '0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + COORD_W'(1);
            end
        end else begin
            h_nxt_s = h_cnt_r + COORD_W'(1);
        end
        act_nxt_s = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
        hs_nxt_s  = !((h_nxt_s >= HS_BEG) && (h_nxt_s <= HS_END));
        vs_nxt_s  = !((v_nxt_s >= VS_BEG) && (v_nxt_s <= VS_END));
    end

    // Stage-0 raster state; (0,0) is an active pixel, so active resets high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_r      <= 1'b0;
            h_cnt_r       <= '0;
            v_cnt_r       <= '0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            active_r      <= 1'b1;
            frame_start_r <= 1'b0;
            restart_r     <= 1'b1;
        end else begin
            pix_en_r      <= ~pix_en_r;
            restart_r     <= 1'b0;
            // A reset restarts the frame at (0,0) without a wrap, so announce it once.
            frame_start_r <= restart_r;
            if (pix_en_r) begin
                h_cnt_r       <= h_nxt_s;
                v_cnt_r       <= v_nxt_s;
                hs_r          <= hs_nxt_s;
                vs_r          <= vs_nxt_s;
                active_r      <= act_nxt_s;
                frame_start_r <= (h_nxt_s == '0) && (v_nxt_s == '0);
            end else begin
                h_cnt_r  <= h_cnt_r;
                v_cnt_r  <= v_cnt_r;
                hs_r     <= hs_r;
                vs_r     <= vs_r;
                active_r <= active_r;
            end
        end
    end

    assign pix_en      = pix_en_r;
    assign h_nxt       = h_nxt_s;
    assign v_nxt       = v_nxt_s;
    assign active_nxt  = act_nxt_s;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign active      = active_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: frame-buffer read addressing, 1-clock read-latency alignment and grey DAC drive.
// Optional VGA_TEST_PATTERN_EN adds test_sel, which replaces buffer data with grey bars.
module vga_scanout
    import vga_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480
) (
    input  logic               CLOCK_50,
    input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_sel,
`endif
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic [DATA_W-1:0]  VGA_R,
    output logic [DATA_W-1:0]  VGA_G,
    output logic [DATA_W-1:0]  VGA_B,
    output logic               frame_start
);

    logic               pix_en_s;
    logic [COORD_W-1:0] h_nxt_s;
    logic [COORD_W-1:0] v_nxt_s;
    logic               act_nxt_s;
    logic               hs_s;
    logic               vs_s;
    logic               active_s;
    logic               frame_start_s;
    logic [COORD_W-1:0] rd_x_r;
    logic [COORD_W-1:0] rd_y_r;
    logic               hs_r;
    logic               vs_r;
    logic               blank_n_r;
    logic [DATA_W-1:0]  grey_r;
    logic [DATA_W-1:0]  pix_src_s;

    vga_timing_gen #(
        .TIMING      (TIMING)
    ) u_timing (
        .clk         (CLOCK_50),
        .reset       (reset),
        .pix_en      (pix_en_s),
        .h_nxt       (h_nxt_s),
        .v_nxt       (v_nxt_s),
        .active_nxt  (act_nxt_s),
        .hs          (hs_s),
        .vs          (vs_s),
        .active      (active_s),
        .frame_start (frame_start_s)
    );

    // Colour source; rd_x_r equals the stage-0 column whenever the pixel is visible.
    always_comb begin
        pix_src_s = rd_data;
`ifdef VGA_TEST_PATTERN_EN
        if (test_sel) begin
            pix_src_s = grey_bar(rd_x_r);
        end else begin
            pix_src_s = rd_data;
        end
`endif
    end

    // Address moves with the counters; pins capture the previous pixel once its data has returned.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_x_r    <= '0;
            rd_y_r    <= '0;
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
            grey_r    <= '0;
        end else if (pix_en_s) begin
            rd_x_r    <= act_nxt_s ? h_nxt_s : '0;
            rd_y_r    <= act_nxt_s ? v_nxt_s : '0;
            hs_r      <= hs_s;
            vs_r      <= vs_s;
            blank_n_r <= active_s;
            grey_r    <= active_s ? pix_src_s : '0;
        end else begin
            rd_x_r    <= rd_x_r;
            rd_y_r    <= rd_y_r;
            hs_r      <= hs_r;
            vs_r      <= vs_r;
            blank_n_r <= blank_n_r;
            grey_r    <= grey_r;
        end
    end

    assign rd_x        = rd_x_r;
    assign rd_y        = rd_y_r;
    assign VGA_CLK     = pix_en_s;
    assign VGA_HS      = hs_r;
    assign VGA_VS      = vs_r;
    assign VGA_BLANK_N = blank_n_r;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = grey_r;
    assign VGA_G       = grey_r;
    assign VGA_B       = grey_r;
    assign frame_start = frame_start_s;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: random buffer contents, position-based reference model.
// Vertical geometry is shortened so whole frames fit in a short run; horizontal timing is standard.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam vga_timing_t TB_T = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 6, v_fp: 2, v_sync: 2, v_bp: 3
    };
    localparam int HA  = 640;
    localparam int HT  = 800;
    localparam int HSB = 656;
    localparam int HSE = 751;
    localparam int VA  = 6;
    localparam int VT  = 13;
    localparam int VSB = 8;
    localparam int VSE = 9;

    logic               clk;
    logic               reset;
    logic               test_sel;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [DATA_W-1:0]  rd_data;
    logic               VGA_CLK;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_BLANK_N;
    logic               VGA_SYNC_N;
    logic [DATA_W-1:0]  VGA_R;
    logic [DATA_W-1:0]  VGA_G;
    logic [DATA_W-1:0]  VGA_B;
    logic               frame_start;

    logic [7:0] lut [256];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int k        = 0;
    int last_fs  = -1;
    int fs_seen  = 0;
    int hs_low   = 0;
    int vs_low   = 0;
    int max_x    = 0;
    int max_y    = 0;

    vga_scanout #(
        .TIMING      (TB_T)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel    (test_sel),
`endif
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_data     (rd_data),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [7:0] buf_val(input int x, input int y);
        return lut[(x + y * 97) & 255];
    endfunction

    // Frame buffer with one clock of read latency.
    always @(posedge clk) rd_data <= buf_val(int'(rd_x), int'(rd_y));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int pix_val(input int x, input int y);
        if (test_sel === 1'b1) return ((x % 512) / 128) * 32;
        else return int'(buf_val(x, y));
    endfunction

    // Expected outputs kk clocks after reset release: stage-0 pixel kk/2, pins one pixel behind.
    task automatic expect_cycle(input int kk);
        int n, x, y, m, px, py, val;
        logic act, pact, fs, hs, vs;
        n   = kk / 2;
        x   = n % HT;
        y   = (n / HT) % VT;
        act = (x < HA) && (y < VA);
        fs  = (kk == 1) || ((kk % 2 == 0) && (kk >= 2) && (x == 0) && (y == 0));
        chk("rd_x", 32'(rd_x), act ? 32'(x) : 32'd0);
        chk("rd_y", 32'(rd_y), act ? 32'(y) : 32'd0);
        chk("vga_clk", 32'(VGA_CLK), 32'(kk % 2));
        chk("frame_start", 32'(frame_start), 32'(fs));
        chk("sync_n", 32'(VGA_SYNC_N), 32'd0);
        if (kk < 2) begin
            pact = 1'b0; hs = 1'b1; vs = 1'b1; val = 0;
        end else begin
            m    = kk / 2 - 1;
            px   = m % HT;
            py   = (m / HT) % VT;
            pact = (px < HA) && (py < VA);
            hs   = !((px >= HSB) && (px <= HSE));
            vs   = !((py >= VSB) && (py <= VSE));
            val  = pact ? pix_val(px, py) : 0;
        end
        chk("hs", 32'(VGA_HS), 32'(hs));
        chk("vs", 32'(VGA_VS), 32'(vs));
        chk("blank_n", 32'(VGA_BLANK_N), 32'(pact));
        chk("r", 32'(VGA_R), 32'(val));
        chk("g", 32'(VGA_G), 32'(val));
        chk("b", 32'(VGA_B), 32'(val));
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            expect_cycle(k);
            if (k >= 2 && frame_start === 1'b1) begin
                if (last_fs >= 0) chk("fs_interval", 32'(k - last_fs), 32'(2 * HT * VT));
                last_fs = k;
                fs_seen++;
            end
            if (k >= 2 && k < 2 + 2 * HT && VGA_HS === 1'b0) hs_low++;
            if (k >= 2 && k < 2 + 2 * HT * VT && VGA_VS === 1'b0) vs_low++;
            if (int'(rd_x) > max_x) max_x = int'(rd_x);
            if (int'(rd_y) > max_y) max_y = int'(rd_y);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_rd_x", 32'(rd_x), 32'd0);
        chk("rst_rd_y", 32'(rd_y), 32'd0);
        chk("rst_hs", 32'(VGA_HS), 32'd1);
        chk("rst_vs", 32'(VGA_VS), 32'd1);
        chk("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
        chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_vga_clk", 32'(VGA_CLK), 32'd0);
    endtask

    initial begin
        int hold, row, target;
        reset    = 1'b1;
        test_sel = 1'b0;
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);

        // Power-on reset of random length, then two full frames of free run.
        hold = $urandom_range(5, 8);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        k = 0;
        run(2 * 2 * HT * VT + 300);
        chk("hs_low_clocks_line0", 32'(hs_low), 32'(2 * 96));
        chk("vs_low_clocks_frame0", 32'(vs_low), 32'(2 * 2 * HT));
        chk("frame_pulses", 32'(fs_seen), 32'd2);
        chk("rd_x_max", 32'(max_x), 32'(HA - 1));
        chk("rd_y_max", 32'(max_y), 32'(VA - 1));

        // Mid-frame reset for one clock at stage-0 position (300,row).
        row    = $urandom_range(1, VA - 1);
        target = 2 * (2 * HT * VT + row * HT + 300);
        run(target - k);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        reset   = 1'b0;
        k       = 0;
        last_fs = -1;
        run(2 * HT + 200);

`ifdef VGA_TEST_PATTERN_EN
        // Grey-bar pattern over one full line.
        test_sel = 1'b1;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        reset   = 1'b0;
        k       = 0;
        last_fs = -1;
        run(2 * HT + 200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
